// File: rtl/pc_sequencer.sv
// Next-PC controller: IDLE/RUN/HALT sequencing with jump, call and return resolution
// and a small return-address stack feeding an external, unreset PC register.
module pc_sequencer #(
  parameter int           D          = 12,
  parameter int           DEPTH      = 4,
  parameter logic [D-1:0] RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         reljump_en,
  input  logic         absjump_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic         halt_req,
  input  logic [D-1:0] target,
  input  logic [D-1:0] pc_cur,
  output logic [D-1:0] pc_next,
  output logic         fetch_valid,
  output logic         halted,
  output logic         stack_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t                    state, state_nxt;
  logic [SPW-1:0]            sp;
  logic [DEPTH-1:0][D-1:0]   stack;
  logic [D-1:0]              pc_inc;
  logic [AW-1:0]             rd_idx, wr_idx;
  logic                      sp_empty, sp_full;
  logic                      push, pop, err_set;

  assign pc_inc   = pc_cur + D'(1);
  assign rd_idx   = AW'(sp - SPW'(1));
  assign wr_idx   = AW'(sp);
  assign sp_empty = (sp == '0);
  assign sp_full  = (sp == SPW'(DEPTH));

  always_comb begin
    state_nxt = state;
    pc_next   = pc_cur;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        pc_next = RESET_ADDR;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (stall) begin
          pc_next = pc_cur;
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (ret_en) begin
          if (!sp_empty) begin
            pc_next = stack[rd_idx];
            pop     = 1'b1;
          end else begin
            pc_next = pc_inc;
            err_set = 1'b1;
          end
        end else if (call_en) begin
          // Overflowing call still jumps; only the push is dropped.
          pc_next = target;
          if (sp_full) err_set = 1'b1;
          else         push    = 1'b1;
        end else if (absjump_en) begin
          pc_next = target;
        end else if (reljump_en) begin
          // Offset is already D bits wide, so modulo-2^D add equals sign-extended add.
          pc_next = pc_cur + target;
        end else begin
          pc_next = pc_inc;
        end
      end
      default: pc_next = pc_cur;
    endcase
    // The PC register has no reset of its own; steer it to RESET_ADDR on the reset edge.
    if (reset) pc_next = RESET_ADDR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push)    sp        <= sp + SPW'(1);
      if (pop)     sp        <= sp - SPW'(1);
      if (err_set) stack_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the program counter register. The PC register is an unreset, D-bit, clocked-load register: prog_ctr_out <= prog_ctr_in every posedge.
- pc_next drives that register's input; pc_cur is fed back from its output.
- Sequences the core through IDLE, RUN and HALT.
- Resolves sequential, relative-jump, absolute-jump, call and return requests.
- Holds a small return-address stack for call/return.

Parameters:
- D, 12, PC width in bits.
- DEPTH, 4, return-stack entries (power of 2, at least 2).
- RESET_ADDR, 0, PC value loaded on reset and while IDLE.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE, begin fetching.
- stall  in  1  hold PC this cycle (RUN only).
- reljump_en  in  1  relative jump request.
- absjump_en  in  1  absolute jump request.
- call_en  in  1  call: push return address, jump absolute.
- ret_en  in  1  return: pop stack, jump there.
- halt_req  in  1  stop fetching.
- target  in  D  jump offset (two's complement, relative) or address (absolute/call).
- pc_cur  in  D  current PC register output.
- pc_next  out  D  next PC, to PC register input (combinational).
- fetch_valid  out  1  high when state is RUN.
- halted  out  1  high when state is HALT.
- stack_err  out  1  sticky overflow/underflow flag.

Behaviour:
- One clock domain (clk). reset is synchronous and active-high. While reset is high:
  - state goes to IDLE; sp (stack pointer, count of valid entries) = 0; stack_err = 0.
  - pc_next = RESET_ADDR combinationally, so the unreset PC loads RESET_ADDR on the same edge.
  - Stack contents are don't-care.
- State IDLE:
  - pc_next = RESET_ADDR; fetch_valid = 0; halted = 0.
  - start = 1 -> RUN next cycle. First fetched PC is RESET_ADDR.
  - Jump, call, return and halt inputs are ignored.
- State RUN (fetch_valid = 1). Evaluate in priority order; only one action per cycle:
  1. stall = 1: pc_next = pc_cur; no stack change; all other requests ignored this cycle.
  2. halt_req = 1: pc_next = pc_cur; state -> HALT.
  3. ret_en = 1:
     - sp > 0: pc_next = stack[sp-1]; sp decrements.
     - sp = 0: underflow; stack_err <= 1; pc_next = pc_cur + 1.
  4. call_en = 1: pc_next = target.
     - sp < DEPTH: stack[sp] <= pc_cur + 1; sp increments.
     - sp = DEPTH: overflow; push discarded; stack_err <= 1; jump still taken.
  5. absjump_en = 1: pc_next = target.
  6. reljump_en = 1: pc_next = pc_cur + sign-extended target.
  7. Otherwise: pc_next = pc_cur + 1.
- All PC arithmetic is D-bit, modulo 2^D. Wrap is silent: pc_cur = 2^D-1 sequential -> 0; relative overflow has no flag.
- State HALT:
  - pc_next = pc_cur; halted = 1; fetch_valid = 0.
  - Exits only via reset; start is ignored.
- stack_err is sticky: it clears only on reset.
- Latency:
  - pc_next is zero-cycle combinational from inputs and state.
  - Stack, sp, state and stack_err update on the posedge of the same cycle.
- A return-address value is written during the call cycle and is readable by a ret in the following cycle.

Test Plan:
- Reset/start: reset 2 cycles, then start=1 -> pc_next=0 during reset and IDLE; after start, PC sequence 0,1,2,3; fetch_valid=1 from the first RUN cycle.
- Relative/absolute jumps:
  - At pc=5, reljump_en with target=12'hFFE (-2) -> next PC 3.
  - At pc=3, absjump_en with target=0x100 -> next PC 0x100.
  - With both asserted at pc=3, target=0x100 -> next PC 0x100 (absolute wins).
- Call/return nesting: call at pc=0x10 to 0x200, call at 0x200 to 0x300, ret, ret -> PCs 0x200, 0x300, 0x201, 0x11; stack_err=0.
- Stack boundaries:
  - 5 calls with DEPTH=4 -> stack_err=1 after the 5th, but the 5th jump is still taken.
  - Ret with empty stack at pc=7 -> pc_next=8, stack_err=1, held through start/halt until reset.
- Stall and halt:
  - stall=1 with call_en=1 at pc=0x20 -> pc holds at 0x20 and sp is unchanged.
  - halt_req at pc=0x40 -> pc stays 0x40 indefinitely; halted=1; start ignored.
- Wrap and mid-run reset:
  - pc=0xFFF sequential -> 0x000.
  - reset asserted mid-RUN with sp=2 -> next PC RESET_ADDR, state IDLE, sp=0, stack_err=0.
